delay_tap_r1: RTL and testbench
===============================

Name: delay_tap_r1

Overview:
- Next-generation vectorized pipeline delay. DEPTH lanes of BIT_WIDTH bits each, packed into flat vectors.
- Adds the following, none of which the previous delay line has:
  - per-stage valid tracking
  - a working active-low stall enable
  - a flush
  - a runtime-selectable output tap, 0..MAX_DELAY
  - an in-flight occupancy counter
- Used for aligning datapath operands and control across pipeline stages of varying latency.

Parameters:
- BIT_WIDTH, 4, bits per lane.
- DEPTH, 2, number of lanes in the packed input/output vectors.
- MAX_DELAY, 4, number of register stages built; the maximum selectable delay. 0 is legal and makes the block pure wiring.
- SEL_W, derived = clog2(MAX_DELAY+1), minimum 1, width of tap select and occupancy. Local; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_n  in  1  active-low enable; 1 = stall, every stage holds.
- flush  in  1  clears all valid bits; has priority over en_n.
- sel  in  SEL_W  tap select: delay in cycles.
- validIn  in  1  qualifies dataIn.
- dataIn  in  BIT_WIDTH*DEPTH  packed input; lane i occupies bits [BIT_WIDTH*i+BIT_WIDTH-1 : BIT_WIDTH*i].
- validOut  out  1  valid at the selected tap.
- dataOut  out  BIT_WIDTH*DEPTH  packed data at the selected tap.
- occupancy  out  SEL_W  count of valid stages among 0..MAX_DELAY-1.

Behaviour:
- Storage: stages s = 0..MAX_DELAY-1, each holding DEPTH lanes of data plus one valid bit.
- rst=1:
  - All data and valid bits clear to 0 on the next edge.
  - Takes priority over flush and en_n.
  - Reset mid-stream discards everything in flight.
  - After reset: validOut=0, occupancy=0, and dataOut=0 for any sel>0.
- Priority when rst=0, evaluated per edge:
  - flush=1: all valid bits go to 0; data registers hold; validIn that cycle is dropped.
  - else en_n=1: every stage (data and valid) holds.
  - else (shift): stage0 <= {dataIn, validIn}; stage s+1 <= stage s.
- Data always shifts when enabled, regardless of valid; valid only qualifies it.
- Tap select, combinational:
  - sel=0: dataOut=dataIn, validOut=validIn (bypass).
  - sel=k, 1<=k<=MAX_DELAY: output stage k-1.
  - sel>MAX_DELAY clamps to MAX_DELAY.
  - A sel change takes effect the same cycle. There is no retiming, so samples may be skipped or repeated; that is the caller's responsibility.
- Latency: with en_n=0 continuously, a sample presented at edge n appears at tap k after edge n+k-1 completes, i.e. visible in cycle n+k.
- Stall: during en_n=1 the outputs are stable; the selected tap still reflects sel changes.
- occupancy:
  - A registered population count of the valid bits, updated with them: increments on a shift that accepts a valid input and drops none; decrements on a shift that pushes a valid bit out of stage MAX_DELAY-1 with no valid input; unchanged on stall.
  - Goes to 0 on flush or rst.
  - Never exceeds MAX_DELAY, with no wrap.
- MAX_DELAY=0: no registers. dataOut=dataIn, validOut=validIn, occupancy=0. sel, en_n and flush are ignored.
- Simultaneous flush and en_n=1: flush wins, valids clear.

Decomposition:
- Shared include/package delay_pkg holds:
  - the clog2 constant function
  - the lane PACK/UNPACK macros
- One sub-module, delay_stage: a single BIT_WIDTH*DEPTH data register plus valid bit, with ports clk, rst, hold, flush, d/vd, q/vq. It is instantiated MAX_DELAY times in a generate chain.
- Tap mux and occupancy counter live in the top level.

Test Plan:
- Reset and defaults: sel=4, validIn=1, stream dataIn=0x00,0x11,0x22,... with en_n=0 → after edge 4, validOut=1 and dataOut=0x00, then 0x11, 0x22 on consecutive cycles; occupancy saturates at 4 and holds there.
- Stall: stream 0xA5,0x5A,0x3C with sel=2, then en_n=1 for 3 cycles → dataOut and occupancy frozen for all 3 cycles; after release, the sequence resumes with no loss or duplication.
- Flush: fill 4 valid samples (occupancy=4), then pulse flush=1 with en_n=1 and validIn=1 → next cycle occupancy=0 and validOut=0 on every tap; the sample presented in the flush cycle never appears.
- Tap sweep: hold a single valid 0x7E pulse, cycle sel=0..4 and sel=7 (clamp) → bypass shows it in cycle 0; tap k shows validOut=1, dataOut=0x7E exactly in cycle k; sel=7 behaves as sel=4.
- Bubbles: validIn pattern 1,0,1,1,0 with sel=3 → validOut reproduces 1,0,1,1,0 delayed 3 cycles; occupancy tracks 1,1,2,3,2 (steady state of the window).
- Reset mid-stream and degenerate build: assert rst with 3 valid samples in flight → next cycle occupancy=0, validOut=0, dataOut=0. Separately, build with MAX_DELAY=0 → dataOut==dataIn every cycle, even while en_n=1 and flush=1.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: shared width helper and lane pack/unpack macros for the delay taps
`ifndef DELAY_PKG_MACROS
`define DELAY_PKG_MACROS
`define DELAY_UNPACK(vec, i, w) vec[(w)*(i) +: (w)]
`define DELAY_PACK(vec, i, w, val) vec[(w)*(i) +: (w)] = (val)
`endif

package delay_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int sel_width(input int max_delay);
        return clog2(max_delay + 1) < 1 ? 1 : clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage: one pipeline register of packed lanes plus its valid bit
module delay_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d,
    input  logic         vd,
    output logic [W-1:0] q,
    output logic         vq
);

    // reset clears everything, flush kills only the valid bit, hold freezes the stage
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            vq <= 1'b0;
        end else if (flush) begin
            vq <= 1'b0;
        end else if (!hold) begin
            q  <= d;
            vq <= vd;
        end
    end

endmodule

// File: rtl/delay_tap_r1.sv
// delay_tap_r1: stallable, flushable delay line with a runtime-selected output tap
module delay_tap_r1
    import delay_pkg::*;
#(
    parameter  int BIT_WIDTH = 4,
    parameter  int DEPTH     = 2,
    parameter  int MAX_DELAY = 4,
    localparam int SEL_W     = sel_width(MAX_DELAY),
    localparam int W         = BIT_WIDTH * DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_n,
    input  logic             flush,
    input  logic [SEL_W-1:0] sel,
    input  logic             validIn,
    input  logic [W-1:0]     dataIn,
    output logic             validOut,
    output logic [W-1:0]     dataOut,
    output logic [SEL_W-1:0] occupancy
);

    if (MAX_DELAY == 0) begin : g_wire
        logic unused;
        assign unused    = ^{clk, rst, en_n, flush, sel};
        assign dataOut   = dataIn;
        assign validOut  = validIn;
        assign occupancy = '0;
    end else begin : g_pipe
        localparam logic [SEL_W-1:0] TOP = SEL_W'(MAX_DELAY);
        logic [W-1:0]     tap_q [MAX_DELAY+1];
        logic             tap_v [MAX_DELAY+1];
        logic [SEL_W-1:0] sel_c;
        logic [SEL_W-1:0] occ;
        assign tap_q[0] = dataIn;
        assign tap_v[0] = validIn;
        for (genvar s = 0; s < MAX_DELAY; s++) begin : g_stage
            delay_stage #(.W(W)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .hold (en_n),
                .flush(flush),
                .d    (tap_q[s]),
                .vd   (tap_v[s]),
                .q    (tap_q[s+1]),
                .vq   (tap_v[s+1])
            );
        end
        assign sel_c = sel > TOP ? TOP : sel;
        // tap 0 is the live input, tap k is the output of stage k-1
        always_comb begin
            dataOut  = dataIn;
            validOut = validIn;
            for (int k = 1; k <= MAX_DELAY; k++) begin
                if (sel_c == SEL_W'(k)) begin
                    dataOut  = tap_q[k];
                    validOut = tap_v[k];
                end
            end
        end
        // population count of stage valids, tracking what enters and leaves on each shift
        always_ff @(posedge clk) begin
            if (rst || flush)
                occ <= '0;
            else if (!en_n)
                occ <= (validIn && !tap_v[MAX_DELAY]) ? occ + 1'b1 :
                       (!validIn && tap_v[MAX_DELAY]) ? occ - 1'b1 : occ;
        end
        assign occupancy = occ;
    end

endmodule

// File: tb/tb_delay_tap_r1.sv
// tb_delay_tap_r1: directed and random checks of the delay tap against a queue model
module tb_delay_tap_r1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en_n, flush, validIn, sel0;
    logic [2:0] sel;
    logic [7:0] dataIn, dataOut, dataOut0;
    logic       validOut, validOut0;
    logic [2:0] occupancy;
    logic       occupancy0;

    int checks = 0;
    int errors = 0;
    bit primed = 1'b0;

    // model: front of the queue is the most recently accepted sample
    logic [7:0] mq[$];
    logic       mv[$];

    delay_tap_r1 dut (
        .clk(clk), .rst(rst), .en_n(en_n), .flush(flush), .sel(sel),
        .validIn(validIn), .dataIn(dataIn),
        .validOut(validOut), .dataOut(dataOut), .occupancy(occupancy)
    );

    delay_tap_r1 #(.MAX_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .en_n(en_n), .flush(flush), .sel(sel0),
        .validIn(validIn), .dataIn(dataIn),
        .validOut(validOut0), .dataOut(dataOut0), .occupancy(occupancy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic v,
                         input logic [7:0] d, input logic [2:0] s);
        int k;
        int occ;
        @(negedge clk);
        rst = r; en_n = e; flush = f; validIn = v; dataIn = d; sel = s; sel0 = s[0];
        #1;
        if (primed) begin
            k = (s > 3'd4) ? 4 : int'(s);
            occ = 0;
            foreach (mv[i]) occ += int'(mv[i]);
            chk("tap_valid", validOut, (k == 0) ? v : mv[k-1]);
            chk("tap_data", dataOut, (k == 0) ? d : mq[k-1]);
            chk("occupancy", occupancy, occ);
        end
        chk("wire_data", dataOut0, d);
        chk("wire_valid", validOut0, v);
        chk("wire_occ", occupancy0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq = '{8'h00, 8'h00, 8'h00, 8'h00};
            mv = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else if (flush) begin
            foreach (mv[i]) mv[i] = 1'b0;
        end else if (!en_n) begin
            mq.push_front(dataIn);
            mv.push_front(validIn);
            void'(mq.pop_back());
            void'(mv.pop_back());
        end
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic [7:0] d, input logic [2:0] s);
        drive(r, e, f, v, d, s);
        tick();
    endtask

    initial begin
        bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int occ_exp[6] = '{0, 1, 1, 2, 3, 2};
        mq = '{8'h00, 8'h00, 8'h00, 8'h00};
        mv = '{1'b0, 1'b0, 1'b0, 1'b0};
        step(1, 0, 0, 0, 8'h00, 3'd0);
        primed = 1'b1;

        // reset defaults and full-depth streaming
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 8'(i * 17), 3'd4);
            chk("def_valid", validOut, (i >= 4) ? 1 : 0);
            chk("def_data", dataOut, (i >= 4) ? (i - 4) * 17 : 0);
            chk("def_occ", occupancy, (i < 4) ? i : 4);
            tick();
        end

        // stall freezes taps and occupancy
        step(1, 0, 0, 0, 8'h00, 3'd2);
        step(0, 0, 0, 1, 8'hA5, 3'd2);
        step(0, 0, 0, 1, 8'h5A, 3'd2);
        step(0, 0, 0, 1, 8'h3C, 3'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 8'hFF, 3'd2);
            chk("stall_data", dataOut, 8'h5A);
            chk("stall_occ", occupancy, 3);
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 3'd2);
        chk("resume_data", dataOut, 8'h5A);
        tick();
        drive(0, 0, 0, 0, 8'h00, 3'd2);
        chk("resume_next", dataOut, 8'h3C);
        tick();

        // flush beats stall and drops the sample offered with it
        step(1, 0, 0, 0, 8'h00, 3'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'(8'h40 + i), 3'd1);
        drive(0, 1, 1, 1, 8'hEE, 3'd1);
        chk("pre_flush_occ", occupancy, 4);
        tick();
        for (int s = 1; s <= 4; s++) begin
            drive(0, 1, 0, 0, 8'h00, 3'(s));
            chk("flush_valid", validOut, 0);
            chk("flush_occ", occupancy, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'h00, 3'(i));

        // single pulse followed through every tap, including the clamp
        step(1, 0, 0, 0, 8'h00, 3'd0);
        drive(0, 0, 0, 1, 8'h7E, 3'd0);
        chk("sweep_v0", validOut, 1);
        chk("sweep_d0", dataOut, 8'h7E);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(0, 0, 0, 0, 8'h00, 3'(c));
            chk("sweep_v", validOut, 1);
            chk("sweep_d", dataOut, 8'h7E);
            tick();
        end
        drive(0, 1, 0, 0, 8'h00, 3'd4);
        chk("sweep_v4", validOut, 1);
        chk("sweep_d4", dataOut, 8'h7E);
        tick();
        drive(0, 0, 0, 0, 8'h00, 3'd7);
        chk("clamp_v", validOut, 1);
        chk("clamp_d", dataOut, 8'h7E);
        tick();
        drive(0, 0, 0, 0, 8'h00, 3'd4);
        chk("sweep_gone", validOut, 0);
        tick();

        // bubbles keep their shape through the window
        step(1, 0, 0, 0, 8'h00, 3'd3);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, (i < 5) ? pat[i] : 1'b0, 8'(8'h10 + i), 3'd3);
            if (i >= 3) chk("bubble_valid", validOut, (i - 3 < 5) ? pat[i-3] : 1'b0);
            if (i <= 5) chk("bubble_occ", occupancy, occ_exp[i]);
            tick();
        end

        // reset discards samples in flight
        step(1, 0, 0, 0, 8'h00, 3'd2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'(8'hC0 + i), 3'd2);
        drive(1, 0, 0, 1, 8'h99, 3'd2);
        chk("pre_rst_occ", occupancy, 3);
        tick();
        drive(0, 1, 1, 1, 8'h5C, 3'd2);
        chk("rst_occ", occupancy, 0);
        chk("rst_valid", validOut, 0);
        chk("rst_data", dataOut, 8'h00);
        tick();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                 8'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
